vram_write_scheduler: RTL and testbench

//  Single-writer front end for the GPU VRAM write bus that feeds the background and sprite blocks.

---
 rtl/gpu_pkg.sv | 16 +
 rtl/vram_write_scheduler_fifo.sv | 52 +++++
 rtl/vram_write_scheduler.sv | 120 ++++++++++++
 tb/tb_vram_write_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared GPU constants: VRAM geometry, region bases decoded downstream, fill engine states.
package gpu_pkg;

  localparam int unsigned VRAM_ADDR_WIDTH = 12;

  localparam logic [11:0] PMB_BASE    = 12'h200;
  localparam logic [11:0] NTBL_BASE   = 12'h400;
  localparam logic [11:0] NTBL_COLORS = 12'h3C0;

  typedef enum logic [1:0] {
    F_IDLE,
    F_RUN,
    F_DONE
  } fill_state_t;

endpackage

// File: rtl/vram_write_scheduler_fifo.sv
// Synchronous FIFO holding queued CPU writes as {address, data}.
module vram_wr_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers are PW bits wide, so power-of-two depth makes them wrap for free.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vram_write_scheduler.sv
// Single-writer VRAM front end: queued CPU writes take priority over the bulk fill engine,
// and nothing is written unless the video timing reports the bus writable.
module vram_write_scheduler
  import gpu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_W     = VRAM_ADDR_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              writable,
  input  logic              cpu_wr_en,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_data,
  output logic              cpu_full,
  output logic              overflow,
  input  logic              fill_start,
  input  logic [ADDR_W-1:0] fill_base,
  input  logic [10:0]       fill_len,
  input  logic [7:0]        fill_value,
  output logic              fill_busy,
  output logic              fill_done,
  output logic [7:0]        data,
  output logic [ADDR_W-1:0] address,
  output logic              write_enable
);

  logic                fifo_full;
  logic                fifo_empty;
  logic [ADDR_W+7:0]   fifo_head;
  logic                push;
  logic                pop;

  fill_state_t         state;
  fill_state_t         state_next;
  logic [ADDR_W-1:0]   base_q;
  logic [10:0]         len_q;
  logic [7:0]          value_q;
  logic [10:0]         idx_q;
  logic                zero_done_q;
  logic [ADDR_W-1:0]   fill_addr;
  logic                fill_issue;
  logic                fill_last;
  logic                fill_accept;

  assign push = cpu_wr_en && !fifo_full;
  assign pop  = writable && !fifo_empty;

  vram_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ADDR_W + 8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({cpu_addr, cpu_data}),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign cpu_full    = fifo_full;
  assign fill_addr   = base_q + ADDR_W'(idx_q);
  assign fill_issue  = writable && fifo_empty && (state == F_RUN);
  assign fill_last   = (idx_q == len_q - 11'd1);
  assign fill_accept = (state == F_IDLE) && fill_start;
  assign fill_busy   = (state != F_IDLE);
  assign fill_done   = (state == F_DONE) || zero_done_q;

  always_comb begin
    state_next = state;
    case (state)
      F_IDLE:  if (fill_start && (fill_len != '0)) state_next = F_RUN;
      F_RUN:   if (fill_issue && fill_last)        state_next = F_DONE;
      F_DONE:  state_next = F_IDLE;
      default: state_next = F_IDLE;
    endcase
  end

  always_comb begin
    write_enable = 1'b0;
    address      = '0;
    data         = '0;
    if (pop) begin
      write_enable    = 1'b1;
      {address, data} = fifo_head;
    end else if (fill_issue) begin
      write_enable = 1'b1;
      address      = fill_addr;
      data         = value_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= F_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      value_q     <= '0;
      idx_q       <= '0;
      zero_done_q <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_next;
      // A zero-length request never enters F_RUN; it only produces the done pulse.
      zero_done_q <= fill_accept && (fill_len == '0);
      if (fill_accept && (fill_len != '0)) begin
        base_q  <= fill_base;
        len_q   <= fill_len;
        value_q <= fill_value;
        idx_q   <= '0;
      end else if (fill_issue) begin
        idx_q <= idx_q + 11'd1;
      end
      if (cpu_wr_en && fifo_full) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Directed bench for vram_write_scheduler with a queue-based reference model checked every cycle.
module tb_vram_write_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        writable = 1'b0;
  logic        cpu_wr_en = 1'b0;
  logic [11:0] cpu_addr = '0;
  logic [7:0]  cpu_data = '0;
  logic        cpu_full;
  logic        overflow;
  logic        fill_start = 1'b0;
  logic [11:0] fill_base = '0;
  logic [10:0] fill_len = '0;
  logic [7:0]  fill_value = '0;
  logic        fill_busy;
  logic        fill_done;
  logic [7:0]  data;
  logic [11:0] address;
  logic        write_enable;

  vram_write_scheduler #(
    .FIFO_DEPTH (16),
    .ADDR_W     (12)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .writable     (writable),
    .cpu_wr_en    (cpu_wr_en),
    .cpu_addr     (cpu_addr),
    .cpu_data     (cpu_data),
    .cpu_full     (cpu_full),
    .overflow     (overflow),
    .fill_start   (fill_start),
    .fill_base    (fill_base),
    .fill_len     (fill_len),
    .fill_value   (fill_value),
    .fill_busy    (fill_busy),
    .fill_done    (fill_done),
    .data         (data),
    .address      (address),
    .write_enable (write_enable)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle", name, act, exp);
    end
  endtask

  typedef struct {
    int unsigned cyc;
    logic [11:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t         log_q[$];
  int unsigned done_cnt = 0;
  int unsigned done_cyc = 0;
  int unsigned cyc = 0;
  bit          armed = 1'b0;

  // Reference model: pending CPU writes, plus the remaining fill bytes and next fill address.
  logic [19:0] mq[$];
  int unsigned rem = 0;
  logic [11:0] m_addr = '0;
  logic [7:0]  m_val = '0;
  bit          done_now = 1'b0;
  bit          done_busy = 1'b0;
  bit          ovf_m = 1'b0;

  bit          ex_we;
  logic [11:0] ex_a;
  logic [7:0]  ex_d;
  int unsigned sz0;
  bit          busy0;
  bit          nd;
  bit          ndb;

  always @(negedge clk) begin
    cyc++;
    ex_we = writable && (mq.size() > 0 || rem > 0);
    ex_a  = '0;
    ex_d  = '0;
    if (ex_we) begin
      if (mq.size() > 0) {ex_a, ex_d} = mq[0];
      else begin
        ex_a = m_addr;
        ex_d = m_val;
      end
    end
    if (armed) begin
      check("write_enable", {31'd0, write_enable}, {31'd0, ex_we});
      check("address", {20'd0, address}, {20'd0, ex_a});
      check("data", {24'd0, data}, {24'd0, ex_d});
      check("cpu_full", {31'd0, cpu_full}, {31'd0, mq.size() == 16});
      check("overflow", {31'd0, overflow}, {31'd0, ovf_m});
      check("fill_busy", {31'd0, fill_busy}, {31'd0, (rem > 0) || (done_now && done_busy)});
      check("fill_done", {31'd0, fill_done}, {31'd0, done_now});
      if (!writable) check("we_gated", {31'd0, write_enable}, 32'd0);
    end
    if (write_enable) log_q.push_back('{cyc, address, data});
    if (fill_done) begin
      done_cnt++;
      done_cyc = cyc;
    end

    if (rst) begin
      mq.delete();
      rem = 0;
      done_now = 1'b0;
      done_busy = 1'b0;
      ovf_m = 1'b0;
    end else begin
      sz0   = mq.size();
      busy0 = (rem > 0) || (done_now && done_busy);
      nd    = 1'b0;
      ndb   = 1'b0;
      if (writable && sz0 > 0) void'(mq.pop_front());
      else if (writable && rem > 0) begin
        m_addr = m_addr + 12'd1;
        rem--;
        if (rem == 0) begin
          nd  = 1'b1;
          ndb = 1'b1;
        end
      end
      if (fill_start && !busy0) begin
        if (fill_len == 0) nd = 1'b1;
        else begin
          rem    = fill_len;
          m_addr = fill_base;
          m_val  = fill_value;
        end
      end
      if (cpu_wr_en) begin
        if (sz0 == 16) ovf_m = 1'b1;
        else mq.push_back({cpu_addr, cpu_data});
      end
      done_now  = nd;
      done_busy = ndb;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name, input int unsigned bound);
    for (int unsigned k = 0; k < bound && done_cnt == 0; k++) tick();
    check(name, done_cnt, 1);
  endtask

  task automatic start_fill(input logic [11:0] b, input logic [10:0] l, input logic [7:0] v);
    fill_base  = b;
    fill_len   = l;
    fill_value = v;
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    armed = 1'b1;
    check("rst_we", {31'd0, write_enable}, 32'd0);
    check("rst_full", {31'd0, cpu_full}, 32'd0);
    check("rst_busy", {31'd0, fill_busy}, 32'd0);
    check("rst_done", {31'd0, fill_done}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_addr_data", {12'd0, address, data}, 32'd0);

    // 1: three queued writes drain in order on consecutive writable cycles
    for (int unsigned i = 0; i < 3; i++) begin
      cpu_wr_en = 1'b1;
      cpu_addr  = 12'h400 + 12'(i);
      cpu_data  = 8'h11 * 8'(i + 1);
      tick();
    end
    cpu_wr_en = 1'b0;
    tick();
    check("t1_no_write_blocked", log_q.size(), 0);
    writable = 1'b1;
    repeat (5) tick();
    writable = 1'b0;
    check("t1_count", log_q.size(), 3);
    if (log_q.size() == 3) begin
      check("t1_w0", {12'd0, log_q[0].a, log_q[0].d}, 32'h0040011);
      check("t1_w1", {12'd0, log_q[1].a, log_q[1].d}, 32'h0040122);
      check("t1_w2", {12'd0, log_q[2].a, log_q[2].d}, 32'h0040233);
      check("t1_consec", log_q[2].cyc - log_q[0].cyc, 2);
    end

    // 2: overfill the queue while blocked
    log_q.delete();
    for (int unsigned i = 0; i < 17; i++) begin
      if (i == 15) check("t2_not_full_15", {31'd0, cpu_full}, 32'd0);
      if (i == 16) check("t2_full_16", {31'd0, cpu_full}, 32'd1);
      cpu_wr_en = 1'b1;
      cpu_addr  = 12'h200 + 12'(i);
      cpu_data  = 8'(i);
      tick();
    end
    cpu_wr_en = 1'b0;
    check("t2_ovf_set", {31'd0, overflow}, 32'd1);
    writable = 1'b1;
    repeat (20) tick();
    check("t2_drain_count", log_q.size(), 16);
    if (log_q.size() == 16) begin
      check("t2_first", {20'd0, log_q[0].a}, 32'h200);
      check("t2_last", {20'd0, log_q[15].a}, 32'h20F);
    end
    check("t2_ovf_sticky", {31'd0, overflow}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t2_ovf_cleared", {31'd0, overflow}, 32'd0);

    // 3: nametable clear
    log_q.delete();
    done_cnt = 0;
    start_fill(12'h400, 11'd960, 8'h00);
    wait_done("t3_done_timeout", 1200);
    tick();
    tick();
    check("t3_count", log_q.size(), 960);
    if (log_q.size() == 960) begin
      check("t3_first", {20'd0, log_q[0].a}, 32'h400);
      check("t3_last", {20'd0, log_q[959].a}, 32'h7BF);
      check("t3_done_cycle", done_cyc, log_q[959].cyc + 1);
    end
    check("t3_done_once", done_cnt, 1);
    check("t3_busy_off", {31'd0, fill_busy}, 32'd0);

    // 4: CPU write interleaved into a running fill
    log_q.delete();
    done_cnt = 0;
    start_fill(12'h000, 11'd40, 8'h5A);
    repeat (9) tick();
    cpu_wr_en = 1'b1;
    cpu_addr  = 12'h3C0;
    cpu_data  = 8'hAB;
    tick();
    cpu_wr_en = 1'b0;
    wait_done("t4_done_timeout", 100);
    check("t4_count", log_q.size(), 41);
    if (log_q.size() == 41) begin
      check("t4_before", {20'd0, log_q[9].a}, 32'h009);
      check("t4_cpu", {12'd0, log_q[10].a, log_q[10].d}, 32'h3C0AB);
      check("t4_resume", {20'd0, log_q[11].a}, 32'h00A);
      check("t4_last", {20'd0, log_q[40].a}, 32'h027);
    end

    // 5: fill across the top of the address space with gated writable
    tick();
    log_q.delete();
    done_cnt = 0;
    start_fill(12'hFFE, 11'd4, 8'hC3);
    for (int unsigned k = 0; k < 32; k++) begin
      writable = ((k / 4) % 2) != 0;
      tick();
    end
    writable = 1'b1;
    check("t5_count", log_q.size(), 4);
    if (log_q.size() == 4) begin
      check("t5_a0", {20'd0, log_q[0].a}, 32'hFFE);
      check("t5_a1", {20'd0, log_q[1].a}, 32'hFFF);
      check("t5_a2", {20'd0, log_q[2].a}, 32'h000);
      check("t5_a3", {20'd0, log_q[3].a}, 32'h001);
    end
    check("t5_done_once", done_cnt, 1);

    // 6: reset aborts a fill; zero-length fill only pulses done
    start_fill(12'h100, 11'd100, 8'h77);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check("t6_rst_outputs", {12'd0, write_enable, fill_busy, fill_done, address, data}, 32'd0);
    rst = 1'b0;
    log_q.delete();
    done_cnt = 0;
    repeat (5) tick();
    check("t6_no_done", done_cnt, 0);
    check("t6_no_writes", log_q.size(), 0);
    start_fill(12'h200, 11'd0, 8'h99);
    check("t6_len0_done", {30'd0, fill_done, fill_busy}, 32'd2);
    tick();
    check("t6_len0_pulse_end", {31'd0, fill_done}, 32'd0);
    repeat (3) tick();
    check("t6_len0_once", done_cnt, 1);
    check("t6_len0_no_writes", log_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
